sram_1mx8_ctrl: RTL and testbench

- Sequences single-byte read/write accesses to the external 1Mx8 asynchronous SRAM/flash-footprint part.
- Presents a simple request/ready/done handshake to on-chip logic.
- Generates CE#/OE#/WE#, the 20-bit address and split data-bus signals; the top level builds the tristate pad from the o_sram_dq_out/o_sram_dq_oe pair.
- Only one access is in flight at a time; no queueing.

---
 rtl/sram_1mx8_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_1mx8_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1mx8_ctrl.sv
// Single-access sequencer for an external 1Mx8 asynchronous SRAM.
// Runs SETUP -> ACCESS (WAIT_CYCLES) -> HOLD per access with fully registered bus outputs.
module sram_1mx8_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [19:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic [7:0]  o_rdata,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic [7:0]  o_sram_dq_out,
    output logic        o_sram_dq_oe,
    input  logic [7:0]  i_sram_dq_in
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("sram_1mx8_ctrl: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } state_e;

    state_e      r_state;
    logic [3:0]  r_wait;
    logic        r_we;
    logic        r_ready;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic [19:0] r_addr;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic [7:0]  r_dq_out;
    logic        r_dq_oe;

    // Each state's bus values are loaded on the edge that enters it, so every pin is a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_wait   <= 4'd0;
            r_we     <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_rdata  <= 8'h00;
            r_addr   <= 20'h00000;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_out <= 8'h00;
            r_dq_oe  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_ready <= 1'b0;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= i_we;
                        r_dq_oe <= i_we;
                        if (i_we) begin
                            r_dq_out <= i_wdata;
                        end
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    // Address has been stable for a full cycle before WE# falls.
                    r_wait <= WaitLoad;
                    if (r_we) begin
                        r_we_n <= 1'b0;
                    end
                    r_state <= StAccess;
                end
                StAccess: begin
                    if (r_wait == 4'd1) begin
                        r_wait <= 4'd0;
                        r_ce_n <= 1'b1;
                        r_oe_n <= 1'b1;
                        r_we_n <= 1'b1;
                        r_done <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= i_sram_dq_in;
                        end
                        r_state <= StHold;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                StHold: begin
                    // Write data is still driven here to cover the part's data hold time.
                    r_dq_oe <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_sram_addr   = r_addr;
    assign o_sram_ce_n   = r_ce_n;
    assign o_sram_oe_n   = r_oe_n;
    assign o_sram_we_n   = r_we_n;
    assign o_sram_dq_out = r_dq_out;
    assign o_sram_dq_oe  = r_dq_oe;

endmodule

// File: tb/tb_sram_1mx8_ctrl.sv
// Directed bench for sram_1mx8_ctrl: main instance with WAIT_CYCLES=2 plus 1 and 15 for the sweep.
module tb_sram_1mx8_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req1 = 1'b0;
    logic        req15 = 1'b0;
    logic        we = 1'b0;
    logic [19:0] addr = 20'h0;
    logic [7:0]  wdata = 8'h0;

    logic        ready, done, ce_n, oe_n, we_n, dq_oe;
    logic [7:0]  rdata, dq_out, dq_in;
    logic [19:0] s_addr;
    logic        ready1, done1, ce_n1, oe_n1, we_n1, dq_oe1;
    logic [7:0]  rdata1, dq_out1;
    logic [19:0] s_addr1;
    logic        ready15, done15, ce_n15, oe_n15, we_n15, dq_oe15;
    logic [7:0]  rdata15, dq_out15;
    logic [19:0] s_addr15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_1mx8_ctrl #(.WAIT_CYCLES(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready), .o_done(done), .o_rdata(rdata), .o_sram_addr(s_addr),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe), .i_sram_dq_in(dq_in)
    );

    sram_1mx8_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready1), .o_done(done1), .o_rdata(rdata1), .o_sram_addr(s_addr1),
        .o_sram_ce_n(ce_n1), .o_sram_oe_n(oe_n1), .o_sram_we_n(we_n1),
        .o_sram_dq_out(dq_out1), .o_sram_dq_oe(dq_oe1), .i_sram_dq_in(8'h5A)
    );

    sram_1mx8_ctrl #(.WAIT_CYCLES(15)) u_dut15 (
        .i_clk(clk), .i_rst(rst), .i_req(req15), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready15), .o_done(done15), .o_rdata(rdata15), .o_sram_addr(s_addr15),
        .o_sram_ce_n(ce_n15), .o_sram_oe_n(oe_n15), .o_sram_we_n(we_n15),
        .o_sram_dq_out(dq_out15), .o_sram_dq_oe(dq_oe15), .i_sram_dq_in(8'h5A)
    );

    // Tiny SRAM model for the main instance, indexed by addr[1:0].
    logic [7:0] mem [4] = '{8'hEE, 8'h00, 8'h00, 8'h3C};
    assign dq_in = (!ce_n && !oe_n) ? mem[s_addr[1:0]] : 8'hFF;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[s_addr[1:0]] <= dq_out;
    end

    // Bus protocol invariants on all three instances, every cycle.
    logic [2:0]  v_we_n, v_oe_n, v_ce_n, v_dq_oe;
    logic [2:0]  p_we_n = 3'b111, p_ce_n = 3'b111;
    logic [19:0] v_addr [3];
    logic [19:0] p_addr [3];
    assign v_we_n  = {we_n15, we_n1, we_n};
    assign v_oe_n  = {oe_n15, oe_n1, oe_n};
    assign v_ce_n  = {ce_n15, ce_n1, ce_n};
    assign v_dq_oe = {dq_oe15, dq_oe1, dq_oe};
    assign v_addr[0] = s_addr;
    assign v_addr[1] = s_addr1;
    assign v_addr[2] = s_addr15;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                checks++;
                if (v_we_n[i] === 1'b0 && v_oe_n[i] === 1'b0) begin
                    errors++;
                    $display("FAIL inv_we_oe dut%0d: we_n=%b oe_n=%b, required not both low",
                             i, v_we_n[i], v_oe_n[i]);
                end
                if (v_dq_oe[i] === 1'b1 && v_oe_n[i] === 1'b0) begin
                    errors++;
                    $display("FAIL inv_dq_oe dut%0d: dq_oe=1 with oe_n=0, required dq_oe=0", i);
                end
                if (p_we_n[i] === 1'b1 && v_we_n[i] === 1'b0 &&
                    (p_ce_n[i] !== 1'b0 || p_addr[i] !== v_addr[i])) begin
                    errors++;
                    $display("FAIL inv_we_fall dut%0d: prev ce_n=%b addr %h->%h, required 0 and stable",
                             i, p_ce_n[i], p_addr[i], v_addr[i]);
                end
                if (p_we_n[i] === 1'b0 && v_we_n[i] === 1'b1 &&
                    (p_addr[i] !== v_addr[i] || v_dq_oe[i] !== 1'b1)) begin
                    errors++;
                    $display("FAIL inv_we_rise dut%0d: addr %h->%h dq_oe=%b, required stable and 1",
                             i, p_addr[i], v_addr[i], v_dq_oe[i]);
                end
            end
            p_we_n[i] <= v_we_n[i];
            p_ce_n[i] <= v_ce_n[i];
            p_addr[i] <= v_addr[i];
        end
    end

    // Per-cycle trace of the main instance; bit/index c is the c-th cycle after the accept edge.
    logic [7:1] tr_ce, tr_we, tr_oe, tr_dqoe, tr_done, tr_ready;
    logic [7:0]  tr_dq [1:7];
    logic [7:0]  tr_rdata [1:7];
    logic [19:0] tr_addr [1:7];

    task automatic do_accept(input logic w, input logic [19:0] a, input logic [7:0] d);
        @(negedge clk);
        we = w; addr = a; wdata = d; req = 1'b1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: ready=%b, required 1", ready);
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    endtask

    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            tr_ce[c] = ce_n; tr_we[c] = we_n; tr_oe[c] = oe_n; tr_dqoe[c] = dq_oe;
            tr_done[c] = done; tr_ready[c] = ready;
            tr_dq[c] = dq_out; tr_rdata[c] = rdata; tr_addr[c] = s_addr;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, done, rdata, s_addr, ce_n, oe_n, we_n, dq_out, dq_oe} !==
            {1'b1, 1'b0, 8'h00, 20'h00000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b done=%b rd=%h a=%h ce=%b oe=%b we=%b dq=%h oe=%b",
                     ready, done, rdata, s_addr, ce_n, oe_n, we_n, dq_out, dq_oe);
        end
        checks++;
        if ({ready1, ce_n1, we_n1, ready15, ce_n15, we_n15} !== 6'b111111) begin
            errors++;
            $display("FAIL reset_sweep_insts: got %b, required 111111",
                     {ready1, ce_n1, we_n1, ready15, ce_n15, we_n15});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b done=%b, required 1 0", ready, done);
        end
    endtask

    task automatic test_write();
        do_accept(1'b1, 20'h12345, 8'hA5);
        capture(7);
        checks++;
        if (tr_ce !== 7'b1111000) begin
            errors++; $display("FAIL wr_ce_n: got %b, required %b", tr_ce, 7'b1111000);
        end
        checks++;
        if (tr_we !== 7'b1111001) begin
            errors++; $display("FAIL wr_we_n: got %b, required %b", tr_we, 7'b1111001);
        end
        checks++;
        if (tr_oe !== 7'b1111111) begin
            errors++; $display("FAIL wr_oe_n: got %b, required %b", tr_oe, 7'b1111111);
        end
        checks++;
        if (tr_dqoe !== 7'b0001111) begin
            errors++; $display("FAIL wr_dq_oe: got %b, required %b", tr_dqoe, 7'b0001111);
        end
        checks++;
        if (tr_dq[1] !== 8'hA5 || tr_dq[4] !== 8'hA5) begin
            errors++; $display("FAIL wr_dq_out: got %h/%h, required a5/a5", tr_dq[1], tr_dq[4]);
        end
        checks++;
        if (tr_done !== 7'b0001000) begin
            errors++; $display("FAIL wr_done: got %b, required %b", tr_done, 7'b0001000);
        end
        checks++;
        if (tr_ready !== 7'b1110000) begin
            errors++; $display("FAIL wr_ready: got %b, required %b", tr_ready, 7'b1110000);
        end
        checks++;
        if (tr_addr[1] !== 20'h12345 || tr_addr[7] !== 20'h12345) begin
            errors++;
            $display("FAIL wr_addr_hold: got %h/%h, required 12345", tr_addr[1], tr_addr[7]);
        end
        checks++;
        if (mem[1] !== 8'hA5) begin
            errors++; $display("FAIL wr_mem: got %h, required a5", mem[1]);
        end
    endtask

    task automatic test_read();
        do_accept(1'b0, 20'hFFFFF, 8'h00);
        capture(7);
        checks++;
        if (tr_oe !== 7'b1111000) begin
            errors++; $display("FAIL rd_oe_n: got %b, required %b", tr_oe, 7'b1111000);
        end
        checks++;
        if (tr_dqoe !== 7'b0000000 || tr_we !== 7'b1111111) begin
            errors++; $display("FAIL rd_dq_oe_we: got %b %b, required all 0 / all 1", tr_dqoe, tr_we);
        end
        checks++;
        if (tr_done !== 7'b0001000) begin
            errors++; $display("FAIL rd_done: got %b, required %b", tr_done, 7'b0001000);
        end
        checks++;
        if (tr_rdata[4] !== 8'h3C) begin
            errors++; $display("FAIL rd_data: got %h, required 3c", tr_rdata[4]);
        end
        do_accept(1'b1, 20'h00002, 8'h77);
        capture(6);
        checks++;
        if (rdata !== 8'h3C || tr_rdata[4] !== 8'h3C) begin
            errors++; $display("FAIL rd_hold: got %h/%h, required 3c", tr_rdata[4], rdata);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        bit seen;
        @(negedge clk);
        we = 1'b1; addr = 20'h00000; wdata = 8'h11; req = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        gap = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                gap = k;
                break;
            end
        end
        @(posedge clk);
        #1 req = 1'b0;
        checks++;
        if (gap != 5) begin
            errors++; $display("FAIL b2b_gap: got %0d cycles, required 5", gap);
        end
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || rdata !== 8'h11) begin
            errors++; $display("FAIL b2b_read: done=%b rdata=%h, required 1 11", seen, rdata);
        end
    endtask

    task automatic test_busy_and_reset();
        int n_done;
        do_accept(1'b1, 20'h00003, 8'h99);
        @(negedge clk);
        @(negedge clk);
        req = 1'b1; we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        n_done = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 1 || ready !== 1'b1 || ce_n !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignored: done pulses=%0d ready=%b ce_n=%b, required 1 1 1",
                     n_done, ready, ce_n);
        end
        do_accept(1'b1, 20'h00001, 8'h42);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (we_n !== 1'b0 || dq_oe !== 1'b1) begin
            errors++; $display("FAIL rst_pre_access: we_n=%b dq_oe=%b, required 0 1", we_n, dq_oe);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({we_n, dq_oe, ce_n, oe_n, ready, done, rdata, s_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 20'h00000}) begin
            errors++;
            $display("FAIL rst_mid_access: we=%b dqoe=%b ce=%b oe=%b rdy=%b done=%b rd=%h a=%h",
                     we_n, dq_oe, ce_n, oe_n, ready, done, rdata, s_addr);
        end
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0 || ready !== 1'b1) begin
            errors++; $display("FAIL rst_no_done: pulses=%0d ready=%b, required 0 1", n_done, ready);
        end
    endtask

    task automatic test_sweep(input bit big);
        int w, we_lo, oe_lo, ce_lo, dq_hi, done_at;
        logic [7:0] rd_at;
        w = big ? 15 : 1;
        // write
        @(negedge clk);
        we = 1'b1; addr = 20'h00005; wdata = 8'h03;
        if (big) req15 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b0; req15 = 1'b0; we = 1'b0;
        we_lo = 0; ce_lo = 0; done_at = 0;
        for (int c = 1; c <= w + 4; c++) begin
            @(negedge clk);
            if ((big ? we_n15 : we_n1) === 1'b0) we_lo++;
            if ((big ? ce_n15 : ce_n1) === 1'b0) ce_lo++;
            if ((big ? done15 : done1) === 1'b1 && done_at == 0) done_at = c;
        end
        checks++;
        if (we_lo != w || ce_lo != w + 1) begin
            errors++;
            $display("FAIL sweep%0d_wr_strobe: we_n low %0d ce_n low %0d, required %0d %0d",
                     w, we_lo, ce_lo, w, w + 1);
        end
        checks++;
        if (done_at != w + 2) begin
            errors++; $display("FAIL sweep%0d_wr_done: got cycle %0d, required %0d", w, done_at, w + 2);
        end
        // read
        @(negedge clk);
        we = 1'b0; addr = 20'h00006;
        if (big) req15 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b0; req15 = 1'b0;
        oe_lo = 0; dq_hi = 0; done_at = 0; rd_at = 8'h00;
        for (int c = 1; c <= w + 4; c++) begin
            @(negedge clk);
            if ((big ? oe_n15 : oe_n1) === 1'b0) oe_lo++;
            if ((big ? dq_oe15 : dq_oe1) === 1'b1) dq_hi++;
            if ((big ? done15 : done1) === 1'b1 && done_at == 0) begin
                done_at = c;
                rd_at = big ? rdata15 : rdata1;
            end
        end
        checks++;
        if (oe_lo != w + 1 || dq_hi != 0) begin
            errors++;
            $display("FAIL sweep%0d_rd_strobe: oe_n low %0d dq_oe high %0d, required %0d 0",
                     w, oe_lo, dq_hi, w + 1);
        end
        checks++;
        if (done_at != w + 2 || rd_at !== 8'h5A) begin
            errors++;
            $display("FAIL sweep%0d_rd_done: cycle %0d data %h, required %0d 5a",
                     w, done_at, rd_at, w + 2);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_and_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
